// File: rtl/serial_seq_tx_if.sv
// Handshake/data bundle between a pattern source (master) and serial_seq_tx (slave).
interface serial_seq_tx_if #(
    parameter int SEQ_LEN = 64
);
    logic               start;
    logic               pause;
    logic               useParam;
    logic [SEQ_LEN-1:0] seqIn;
    logic [3:0]         repeatCount;
    logic               x;
    logic               xValid;
    logic               busy;
    logic               done;
    logic [2:0]         stateReg;

    modport master (
        output start, pause, useParam, seqIn, repeatCount,
        input  x, xValid, busy, done, stateReg
    );

    modport slave (
        input  start, pause, useParam, seqIn, repeatCount,
        output x, xValid, busy, done, stateReg
    );
endinterface

// File: rtl/serial_seq_tx.sv
// Serial test-sequence transmitter: shifts a captured pattern out MSB-first,
// repeats it with idle gaps, supports pause/resume and pulses done at the end.
module serial_seq_tx #(
    parameter int          SEQ_LEN     = 64,
    parameter logic [63:0] SEQ_DEFAULT = 64'b0001100000110011000011000001100000110000110000110000110000110000,
    parameter int          GAP_CYCLES  = 2
) (
    input  logic           clk,
    input  logic           rst,
    serial_seq_tx_if.slave bus
);
    localparam int CW = $clog2(SEQ_LEN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_LOAD  = 3'b001,
        S_SHIFT = 3'b010,
        S_HOLD  = 3'b011,
        S_GAP   = 3'b100,
        S_DONE  = 3'b101
    } state_t;

    state_t             state_q, state_d;
    logic [SEQ_LEN-1:0] shift_q, shift_d;
    logic [SEQ_LEN-1:0] seq_q, seq_d;
    logic [CW-1:0]      bitcnt_q, bitcnt_d;
    logic [7:0]         gapcnt_q, gapcnt_d;
    logic [3:0]         pass_q, pass_d;
    logic               x_q, x_d;
    logic               xvalid_q, xvalid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_bit;

    assign last_bit = (bitcnt_q == CW'(SEQ_LEN - 1));

    // Next-state and datapath decode; outputs are derived from the next-state
    // values so the registered outputs always match the state they describe.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        seq_d    = seq_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        pass_d   = pass_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    seq_d   = bus.useParam ? SEQ_DEFAULT[SEQ_LEN-1:0] : bus.seqIn;
                    pass_d  = (bus.repeatCount == 4'd0) ? 4'd1 : bus.repeatCount;
                end
            end
            S_LOAD: begin
                shift_d  = seq_q;
                bitcnt_d = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                shift_d  = {shift_q[SEQ_LEN-2:0], 1'b0};
                bitcnt_d = bitcnt_q + CW'(1);
                // End of pass wins over pause so the final bit never stalls.
                if (last_bit) begin
                    if (pass_q > 4'd1) begin
                        pass_d   = pass_q - 4'd1;
                        gapcnt_d = 8'd0;
                        state_d  = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (bus.pause) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!bus.pause) state_d = S_SHIFT;
            end
            S_GAP: begin
                gapcnt_d = gapcnt_q + 8'd1;
                if (gapcnt_q == 8'(GAP_CYCLES - 1)) state_d = S_LOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        x_d      = ((state_d == S_SHIFT) || (state_d == S_HOLD)) ? shift_d[SEQ_LEN-1] : 1'b0;
        xvalid_d = (state_d == S_SHIFT);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            seq_q    <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            pass_q   <= '0;
            x_q      <= 1'b0;
            xvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            seq_q    <= seq_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            pass_q   <= pass_d;
            x_q      <= x_d;
            xvalid_q <= xvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.x        = x_q;
    assign bus.xValid   = xvalid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.stateReg = state_q;
endmodule

// File: tb/tb_serial_seq_tx.sv
// Directed bench for serial_seq_tx (SEQ_LEN=64, GAP_CYCLES=2).
module tb_serial_seq_tx;
    localparam int          L   = 64;
    localparam int          G   = 2;
    localparam logic [63:0] DEF = 64'b0001100000110011000011000001100000110000110000110000110000110000;
    localparam logic [63:0] PB  = 64'hB2C3_5A0F_1E2D_3C4B;
    localparam int          NOP = 100000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_seq_tx_if #(.SEQ_LEN(L)) bus ();

    serial_seq_tx #(.SEQ_LEN(L), .SEQ_DEFAULT(DEF), .GAP_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    logic q_bits[$];
    int   q_idx[$];
    logic q_hold[$];
    int   done_at;
    int   done_n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge (E0); returns just after E0.
    task automatic do_start(input logic up, input logic [63:0] s, input logic [3:0] rc);
        bus.useParam    = up;
        bus.seqIn       = s;
        bus.repeatCount = rc;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Clock k = 1..maxc edges after E0, logging valid bits and done.
    // mode 1: pulse start mid-SHIFT and on the edge leaving DONE.
    // mode 2: scramble the captured inputs at k=10.
    task automatic run(input int maxc, input int p_at, input int p_len, input int mode);
        q_bits.delete();
        q_idx.delete();
        q_hold.delete();
        done_at = -1;
        done_n  = 0;
        for (int k = 1; k <= maxc; k++) begin
            bus.pause = (k >= p_at) && (k < p_at + p_len);
            if (mode == 1) bus.start = (k == 30) || (done_n > 0 && done_at == k - 1);
            if (mode == 2 && k == 10) begin
                bus.seqIn       = ~bus.seqIn;
                bus.useParam    = ~bus.useParam;
                bus.repeatCount = 4'd0;
            end
            tick();
            if (bus.xValid) begin
                q_bits.push_back(bus.x);
                q_idx.push_back(k);
            end
            if (bus.stateReg == 3'b011) q_hold.push_back(bus.x);
            if (bus.done) begin
                done_n++;
                done_at = k;
            end
            if (done_n > 0 && !bus.done) break;
        end
        bus.pause = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic chk_stream(input string tag, input logic [63:0] pat, input int r);
        int nerr;
        nerr = 0;
        chk({tag, "_len"}, 64'(q_bits.size()), 64'(r * L));
        for (int i = 0; i < q_bits.size(); i++)
            if (q_bits[i] !== pat[L-1-(i%L)]) nerr++;
        chk({tag, "_bits"}, 64'(nerr), 64'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {59'd0, bus.stateReg, bus.busy, bus.done}, 64'd0);
    endtask

    initial begin
        logic [5:0] first6;
        int nerr;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.useParam    = 1'b0;
        bus.seqIn       = '0;
        bus.repeatCount = 4'd0;
        #23;
        chk("reset_outs", {59'd0, bus.x, bus.xValid, bus.busy, bus.done, 1'b0}, 64'd0);
        chk("reset_state", 64'(bus.stateReg), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Default pattern, single pass.
        do_start(1'b1, 64'd0, 4'd1);
        chk("load_state", {bus.stateReg, bus.busy, bus.xValid}, {3'b001, 1'b1, 1'b0});
        run(300, NOP, 0, 0);
        chk("A_done_at", 64'(done_at), 64'd65);
        chk("A_done_n", 64'(done_n), 64'd1);
        chk_stream("A", DEF, 1);
        first6 = {q_bits[0], q_bits[1], q_bits[2], q_bits[3], q_bits[4], q_bits[5]};
        chk("A_first6", 64'(first6), 64'b000110);
        chk("A_first_idx", 64'(q_idx[0]), 64'd1);
        chk("A_last_idx", 64'(q_idx[63]), 64'd64);
        chk_idle("A_idle");

        // Custom pattern, three passes with gaps.
        do_start(1'b0, PB, 4'd3);
        run(400, NOP, 0, 0);
        chk("B_done_at", 64'(done_at), 64'd199);
        chk_stream("B", PB, 3);
        chk("B_gap1", 64'(q_idx[64] - q_idx[63]), 64'd4);
        chk("B_gap2", 64'(q_idx[128] - q_idx[127]), 64'd4);
        chk_idle("B_idle");

        // Pause for 5 edges starting at the edge that ends bit 10.
        do_start(1'b1, 64'd0, 4'd1);
        run(300, 12, 5, 0);
        chk("P_done_at", 64'(done_at), 64'd70);
        chk_stream("P", DEF, 1);
        chk("P_idx10", 64'(q_idx[10]), 64'd11);
        chk("P_idx11", 64'(q_idx[11]), 64'd17);
        chk("P_hold_len", 64'(q_hold.size()), 64'd5);
        nerr = 0;
        foreach (q_hold[i]) if (q_hold[i] !== 1'b1) nerr++;
        chk("P_hold_x", 64'(nerr), 64'd0);

        // Pause arriving on the final-bit edge goes straight to DONE.
        do_start(1'b1, 64'd0, 4'd1);
        run(300, 65, 3, 0);
        chk("F_done_at", 64'(done_at), 64'd65);
        chk("F_no_hold", 64'(q_hold.size()), 64'd0);
        chk_stream("F", DEF, 1);

        // repeatCount 0 behaves as a single pass.
        do_start(1'b0, PB, 4'd0);
        run(300, NOP, 0, 0);
        chk("Z_done_at", 64'(done_at), 64'd65);
        chk_stream("Z", PB, 1);

        // Start pulses in SHIFT and in DONE are ignored.
        do_start(1'b1, 64'd0, 4'd1);
        run(300, NOP, 0, 1);
        chk("S_done_at", 64'(done_at), 64'd65);
        chk("S_done_n", 64'(done_n), 64'd1);
        chk_stream("S", DEF, 1);
        tick();
        chk_idle("S_idle");

        // Inputs changed after capture have no effect on either pass.
        do_start(1'b0, PB, 4'd2);
        run(300, NOP, 0, 2);
        chk("M_done_at", 64'(done_at), 64'd132);
        chk_stream("M", PB, 2);

        // Asynchronous reset mid-SHIFT, then a clean restart.
        do_start(1'b1, 64'd0, 4'd1);
        run(20, NOP, 0, 0);
        chk("R_mid_state", 64'(bus.stateReg), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("R_async_outs", {59'd0, bus.x, bus.xValid, bus.busy, bus.done, 1'b0}, 64'd0);
        chk("R_async_state", 64'(bus.stateReg), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_start(1'b1, 64'd0, 4'd1);
        run(300, NOP, 0, 0);
        chk("R_done_at", 64'(done_at), 64'd65);
        chk_stream("R", DEF, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
